// File: rtl/pc_unit.sv
// Fetch-stage program counter: sequential/stall/branch/exception next-PC
// selection with a circular return-address stack for call/return prediction.
module pc_unit #(
   parameter int                    DATA_WIDTH   = 32,
   parameter int                    PC_STEP      = 4,
   parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [DATA_WIDTH-1:0] EXC_VECTOR   = 32'h0000_0008,
   parameter int                    RAS_DEPTH    = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_Stall,
   input  logic                  i_Branch,
   input  logic [DATA_WIDTH-1:0] i_BranchTarget,
   input  logic                  i_Call,
   input  logic                  i_Return,
   input  logic                  i_Exception,
   output logic [DATA_WIDTH-1:0] o_PC,
   output logic [DATA_WIDTH-1:0] o_PCPlus,
   output logic                  o_Valid,
   output logic                  o_RasEmpty,
   output logic                  o_RasFull,
   output logic                  o_RasUnderflow
);

   localparam int AW = $clog2(RAS_DEPTH);
   localparam int CW = $clog2(RAS_DEPTH + 1);
   localparam logic [DATA_WIDTH-1:0] STEP       = DATA_WIDTH'(PC_STEP);
   localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~(STEP - 1'b1);
   localparam logic [CW-1:0]         CNT_MAX    = CW'(RAS_DEPTH);

   typedef enum logic {HOLD, RUN} state_t;

   state_t                state, state_nxt;
   logic [DATA_WIDTH-1:0] pc, pc_nxt;
   logic [DATA_WIDTH-1:0] ras [RAS_DEPTH];
   logic [AW-1:0]         top, top_nxt;
   logic [CW-1:0]         cnt, cnt_nxt;
   logic                  push, uf_set;
   logic                  ras_empty, ras_full, ras_uf;

   assign o_PC           = pc;
   assign o_PCPlus       = pc + STEP;
   assign o_Valid        = (state == RUN);
   assign o_RasEmpty     = ras_empty;
   assign o_RasFull      = ras_full;
   assign o_RasUnderflow = ras_uf;

   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      top_nxt   = top;
      cnt_nxt   = cnt;
      push      = 1'b0;
      uf_set    = 1'b0;
      case (state)
         HOLD: state_nxt = RUN;  // first valid fetch is RESET_VECTOR itself
         RUN: begin
            if (i_Exception) begin
               pc_nxt  = EXC_VECTOR;
               cnt_nxt = '0;
            end else if (i_Branch) begin
               pc_nxt = i_BranchTarget & ALIGN_MASK;
               if (i_Call) begin
                  // when full, top+1 lands on the oldest entry and overwrites it
                  push    = 1'b1;
                  top_nxt = top + AW'(1);
                  cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
               end
            end else if (i_Return && cnt != '0) begin
               pc_nxt  = ras[top];
               top_nxt = top - AW'(1);
               cnt_nxt = cnt - CW'(1);
            end else if (i_Return) begin
               pc_nxt = o_PCPlus;
               uf_set = 1'b1;
            end else if (!i_Stall) begin
               pc_nxt = o_PCPlus;
            end
         end
         default: state_nxt = HOLD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= HOLD;
         pc        <= RESET_VECTOR;
         top       <= '0;
         cnt       <= '0;
         ras_empty <= 1'b1;
         ras_full  <= 1'b0;
         ras_uf    <= 1'b0;
      end else begin
         state     <= state_nxt;
         pc        <= pc_nxt;
         top       <= top_nxt;
         cnt       <= cnt_nxt;
         ras_empty <= (cnt_nxt == '0);
         ras_full  <= (cnt_nxt == CNT_MAX);
         ras_uf    <= ras_uf | uf_set;
      end
   end

   // Stack storage needs no reset: entries are only read while count > 0.
   always_ff @(posedge clk) begin
      if (!reset && push) ras[top_nxt] <= o_PCPlus;
   end

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: reset/release, stall, branch, call/return,
// RAS overflow/underflow, exception flush, wrap and reset-vs-redirect.
module tb_pc_unit;
   logic        clk = 1'b0;
   logic        reset, i_Stall, i_Branch, i_Call, i_Return, i_Exception;
   logic [31:0] i_BranchTarget;
   logic [31:0] o_PC, o_PCPlus;
   logic        o_Valid, o_RasEmpty, o_RasFull, o_RasUnderflow;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   pc_unit dut (
      .clk(clk), .reset(reset), .i_Stall(i_Stall), .i_Branch(i_Branch),
      .i_BranchTarget(i_BranchTarget), .i_Call(i_Call), .i_Return(i_Return),
      .i_Exception(i_Exception), .o_PC(o_PC), .o_PCPlus(o_PCPlus),
      .o_Valid(o_Valid), .o_RasEmpty(o_RasEmpty), .o_RasFull(o_RasFull),
      .o_RasUnderflow(o_RasUnderflow)
   );

   task automatic idle_inputs();
      i_Stall = 0; i_Branch = 0; i_Call = 0; i_Return = 0; i_Exception = 0;
      i_BranchTarget = 32'h0;
   endtask

   task automatic step();
      @(posedge clk); #1;
      idle_inputs();
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1; step(); step();
      reset = 0; step();
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1; step(); step();
      checks++; if (o_PC !== 32'h0) begin errors++; $display("FAIL rst_pc got %h exp %h", o_PC, 32'h0); end
      checks++; if (o_Valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", o_Valid); end
      checks++; if ({o_RasEmpty, o_RasFull, o_RasUnderflow} !== 3'b100) begin errors++; $display("FAIL rst_ras got %b exp 100", {o_RasEmpty, o_RasFull, o_RasUnderflow}); end
      reset = 0; step();
      checks++; if (o_PC !== 32'h0 || o_Valid !== 1'b1) begin errors++; $display("FAIL release got pc %h v %b exp 0 1", o_PC, o_Valid); end
      step();
      checks++; if (o_PC !== 32'h4) begin errors++; $display("FAIL seq1 got %h exp 4", o_PC); end
      step();
      checks++; if (o_PC !== 32'h8) begin errors++; $display("FAIL seq2 got %h exp 8", o_PC); end
      step();
      checks++; if (o_PC !== 32'hC || o_PCPlus !== 32'h10) begin errors++; $display("FAIL seq3 got %h/%h exp c/10", o_PC, o_PCPlus); end
   endtask

   task automatic test_stall();
      step();
      i_Stall = 1; step();
      checks++; if (o_PC !== 32'h10) begin errors++; $display("FAIL stall1 got %h exp 10", o_PC); end
      i_Stall = 1; step();
      checks++; if (o_PC !== 32'h10) begin errors++; $display("FAIL stall2 got %h exp 10", o_PC); end
      i_Stall = 1; i_Branch = 1; i_BranchTarget = 32'h2000_0003; step();
      checks++; if (o_PC !== 32'h2000_0000) begin errors++; $display("FAIL stall_branch got %h exp 20000000", o_PC); end
   endtask

   task automatic test_call_return();
      do_reset();
      i_Branch = 1; i_BranchTarget = 32'h100; step();
      i_Branch = 1; i_Call = 1; i_BranchTarget = 32'h400; step();
      checks++; if (o_PC !== 32'h400 || o_RasEmpty !== 1'b0) begin errors++; $display("FAIL call1 got %h e %b exp 400 0", o_PC, o_RasEmpty); end
      step();
      i_Branch = 1; i_Call = 1; i_BranchTarget = 32'h800; step();
      checks++; if (o_PC !== 32'h800) begin errors++; $display("FAIL call2 got %h exp 800", o_PC); end
      i_Return = 1; step();
      checks++; if (o_PC !== 32'h408) begin errors++; $display("FAIL ret1 got %h exp 408", o_PC); end
      step();
      checks++; if (o_PC !== 32'h40C) begin errors++; $display("FAIL after_ret got %h exp 40c", o_PC); end
      i_Return = 1; step();
      checks++; if (o_PC !== 32'h104 || o_RasEmpty !== 1'b1) begin errors++; $display("FAIL ret2 got %h e %b exp 104 1", o_PC, o_RasEmpty); end
   endtask

   task automatic test_priority();
      do_reset();
      i_Call = 1; step();
      checks++; if (o_PC !== 32'h4 || o_RasEmpty !== 1'b1) begin errors++; $display("FAIL call_alone got %h e %b exp 4 1", o_PC, o_RasEmpty); end
      i_Branch = 1; i_Call = 1; i_BranchTarget = 32'h100; step();
      i_Branch = 1; i_Return = 1; i_BranchTarget = 32'h200; step();
      checks++; if (o_PC !== 32'h200 || o_RasEmpty !== 1'b0) begin errors++; $display("FAIL br_ret got %h e %b exp 200 0", o_PC, o_RasEmpty); end
      i_Return = 1; step();
      checks++; if (o_PC !== 32'h8) begin errors++; $display("FAIL br_ret_nopop got %h exp 8", o_PC); end
   endtask

   task automatic test_overflow();
      logic [31:0] exp_ret [4];
      exp_ret[0] = 32'h4004; exp_ret[1] = 32'h3004; exp_ret[2] = 32'h2004; exp_ret[3] = 32'h1004;
      do_reset();
      for (int i = 1; i <= 5; i++) begin
         i_Branch = 1; i_Call = 1; i_BranchTarget = 32'(i) << 12; step();
         if (i == 4) begin
            checks++; if (o_RasFull !== 1'b1) begin errors++; $display("FAIL full4 got %b exp 1", o_RasFull); end
         end
      end
      checks++; if (o_RasFull !== 1'b1 || o_PC !== 32'h5000) begin errors++; $display("FAIL full5 got f %b pc %h exp 1 5000", o_RasFull, o_PC); end
      for (int i = 0; i < 4; i++) begin
         i_Return = 1; step();
         checks++; if (o_PC !== exp_ret[i]) begin errors++; $display("FAIL ovf_ret%0d got %h exp %h", i, o_PC, exp_ret[i]); end
      end
      checks++; if (o_RasEmpty !== 1'b1 || o_RasUnderflow !== 1'b0) begin errors++; $display("FAIL ovf_empty got e %b u %b exp 1 0", o_RasEmpty, o_RasUnderflow); end
      i_Return = 1; step();
      checks++; if (o_PC !== 32'h1008 || o_RasUnderflow !== 1'b1) begin errors++; $display("FAIL underflow got %h u %b exp 1008 1", o_PC, o_RasUnderflow); end
      step();
      checks++; if (o_RasUnderflow !== 1'b1) begin errors++; $display("FAIL uf_sticky got %b exp 1", o_RasUnderflow); end
   endtask

   task automatic test_exception();
      do_reset();
      i_Branch = 1; i_Call = 1; i_BranchTarget = 32'h100; step();
      i_Branch = 1; i_Call = 1; i_BranchTarget = 32'h200; step();
      i_Exception = 1; i_Branch = 1; i_Return = 1; i_Call = 1; i_Stall = 1; i_BranchTarget = 32'h300; step();
      checks++; if (o_PC !== 32'h8 || o_RasEmpty !== 1'b1) begin errors++; $display("FAIL exc got %h e %b exp 8 1", o_PC, o_RasEmpty); end
      i_Return = 1; step();
      checks++; if (o_PC !== 32'hC || o_RasUnderflow !== 1'b1) begin errors++; $display("FAIL exc_flush got %h u %b exp c 1", o_PC, o_RasUnderflow); end
   endtask

   task automatic test_wrap();
      i_Branch = 1; i_BranchTarget = 32'hFFFF_FFFC; step();
      checks++; if (o_PC !== 32'hFFFF_FFFC || o_PCPlus !== 32'h0) begin errors++; $display("FAIL wrap_pre got %h/%h exp fffffffc/0", o_PC, o_PCPlus); end
      step();
      checks++; if (o_PC !== 32'h0 || o_Valid !== 1'b1) begin errors++; $display("FAIL wrap got %h v %b exp 0 1", o_PC, o_Valid); end
      step();
      reset = 1; i_Branch = 1; i_BranchTarget = 32'h300; step();
      checks++; if (o_PC !== 32'h0 || o_Valid !== 1'b0 || o_RasUnderflow !== 1'b0) begin errors++; $display("FAIL rst_branch got %h v %b u %b exp 0 0 0", o_PC, o_Valid, o_RasUnderflow); end
      reset = 0; step();
      checks++; if (o_PC !== 32'h0 || o_Valid !== 1'b1) begin errors++; $display("FAIL rerun got %h v %b exp 0 1", o_PC, o_Valid); end
   endtask

   initial begin
      reset = 1;
      idle_inputs();
      test_reset();
      test_stall();
      test_call_return();
      test_priority();
      test_overflow();
      test_exception();
      test_wrap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised next-generation program counter for the pipeline fetch stage, succeeding the plain load/hold PC register.
- Generates the fetch PC every cycle: sequential increment, stall hold, branch redirect, exception vectoring, and call/return prediction through an internal return-address stack (RAS).
- Feeds the instruction-memory address and the IF/ID pipeline register.

Parameters:
- DATA_WIDTH, 32, PC width in bits
- PC_STEP, 4, byte increment per sequential fetch; power of two, at least 1
- RESET_VECTOR, 32'h0000_0000, PC value loaded by reset
- EXC_VECTOR, 32'h0000_0008, PC value loaded on exception
- RAS_DEPTH, 4, return-address stack entries; power of two, at least 2

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- i_Stall  in  1  hold PC this cycle
- i_Branch  in  1  redirect to i_BranchTarget
- i_BranchTarget  in  DATA_WIDTH  branch/call target address
- i_Call  in  1  push return address; only meaningful with i_Branch
- i_Return  in  1  redirect to RAS top and pop
- i_Exception  in  1  redirect to EXC_VECTOR and flush RAS
- o_PC  out  DATA_WIDTH  current fetch PC (registered)
- o_PCPlus  out  DATA_WIDTH  o_PC + PC_STEP (combinational, modulo 2^DATA_WIDTH)
- o_Valid  out  1  o_PC is a valid fetch address
- o_RasEmpty  out  1  RAS holds zero entries
- o_RasFull  out  1  RAS holds RAS_DEPTH entries
- o_RasUnderflow  out  1  sticky flag: a return was issued while the RAS was empty

Behaviour:
- All state updates on the rising clk edge. Next PC is visible on o_PC one cycle after the controlling inputs are sampled (latency 1).
- Reset (highest priority):
  - o_PC = RESET_VECTOR, o_Valid = 0, RAS count = 0, o_RasEmpty = 1, o_RasFull = 0, o_RasUnderflow = 0.
  - All other inputs are ignored while reset is high.
  - Reset asserted mid-operation discards any in-flight redirect.
- Control FSM has two states, HOLD and RUN.
  - Reset forces HOLD.
  - HOLD to RUN on the first edge with reset low. o_Valid = 1 in RUN.
  - On that HOLD-to-RUN edge, o_PC stays at RESET_VECTOR: the first valid fetch is RESET_VECTOR, and the PC does not advance on that edge.
- Next-PC priority in RUN, highest first:
  1. i_Exception: o_PC = EXC_VECTOR; RAS flushed (count = 0); i_Call and i_Return ignored.
  2. i_Branch: o_PC = i_BranchTarget with the low log2(PC_STEP) bits cleared. If i_Call is also high, push o_PCPlus.
  3. i_Return with RAS not empty: o_PC = RAS top; pop.
  4. i_Return with RAS empty: treated as the increment case; o_RasUnderflow set to 1 (sticky until reset).
  5. i_Stall: o_PC unchanged.
  6. Otherwise: o_PC = o_PCPlus.
- Redirects (cases 1–4) override i_Stall; a stall never blocks a redirect.
- i_Call without i_Branch is ignored.
- i_Branch and i_Return together: the branch wins, and no pop occurs.
- Arithmetic:
  - o_PCPlus wraps modulo 2^DATA_WIDTH, e.g. 32'hFFFF_FFFC + 4 = 32'h0.
  - RAS entries are DATA_WIDTH wide.
- RAS structure: circular buffer with a top pointer and a saturating count (0..RAS_DEPTH).
  - Push when full: overwrite the oldest entry; count stays RAS_DEPTH; o_RasFull stays 1.
  - Pop: count decrements; the pointer moves back.
  - o_RasEmpty = (count == 0); o_RasFull = (count == RAS_DEPTH), both registered.

Test Plan:
- Reset then release: o_PC = 0, o_Valid = 0 during reset. First cycle after release: o_PC = 0, o_Valid = 1. Then 4, 8, 0xC on successive free-running cycles.
- Stall two cycles at o_PC = 0x10 → o_PC stays 0x10. Assert i_Branch (target 0x2000_0003) with i_Stall still high → next o_PC = 0x2000_0000.
- Call/return, one instruction per cycle so o_PC advances by 4 between them:
  - At o_PC = 0x100, i_Branch + i_Call to 0x400 → o_PC = 0x400, o_RasEmpty = 0.
  - At o_PC = 0x404, i_Branch + i_Call to 0x800 → o_PC = 0x800, RAS holds 0x104 and 0x408.
  - i_Return → o_PC = 0x408. Next cycle o_PC = 0x40C.
  - i_Return → o_PC = 0x104, o_RasEmpty = 1.
- RAS overflow with RAS_DEPTH = 4: five calls from PCs A1..A5 → o_RasFull = 1. Four returns yield A5+4, A4+4, A3+4, A2+4. A fifth return → o_PC = previous o_PC + 4 and o_RasUnderflow = 1.
- Exception with i_Branch and i_Return also high, RAS holding 2 entries → o_PC = 0x8, o_RasEmpty = 1. Branch and return are both discarded.
- Wrap: branch to 0xFFFF_FFFC, then free-run → o_PC = 0x0 with o_Valid = 1. Reset asserted together with i_Branch → o_PC = RESET_VECTOR, o_Valid = 0, o_RasUnderflow = 0.
